// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver (8N1/8E1/8O1) pushing good bytes into the Rx FIFO with one-cycle error pulses
module uart_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx_in,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 fifo_full,
  output logic                 push,
  output logic [7:0]           push_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic rx_s1_q, rxs_q;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d, baud_div_l_q, baud_div_l_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, push_data_q, push_data_d;
  logic perr_q, perr_d, push_q, push_d, parity_err_q, parity_err_d;
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic tick, mid, bit_end;
  assign tick    = div_cnt_q == baud_div_l_q;
  assign mid     = tick && samp_cnt_q == SW'(OVERSAMPLE / 2 - 1);
  assign bit_end = tick && samp_cnt_q == SW'(OVERSAMPLE - 1);
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
    samp_cnt_d   = bit_end ? '0 : (tick ? samp_cnt_q + SW'(1) : samp_cnt_q);
    baud_div_l_d = baud_div_l_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    case (state_q)
      IDLE: begin
        div_cnt_d  = '0;
        samp_cnt_d = '0;
        if (!rxs_q) begin
          state_d      = START;
          baud_div_l_d = baud_div;
          perr_d       = 1'b0;
        end
      end
      START: begin
        if (mid && rxs_q) state_d = IDLE;
        else if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (mid) shift_d[bit_cnt_q] = rxs_q;
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = parity_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (mid) perr_d = rxs_q != (^shift_q ^ parity_odd);
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Decide at mid stop bit so the next start edge can be caught right away
        if (mid && rxs_q) begin
          push_d       = !fifo_full;
          overrun_d    = fifo_full;
          parity_err_d = perr_q;
          push_data_d  = fifo_full ? push_data_q : shift_q;
          state_d      = IDLE;
        end else if (mid) begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: state_d = rxs_q ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_s1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      div_cnt_q    <= '0;
      baud_div_l_q <= '0;
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_s1_q      <= rx_in;
      rxs_q        <= rx_s1_q;
      div_cnt_q    <= div_cnt_d;
      baud_div_l_q <= baud_div_l_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end
  assign push        = push_q;
  assign push_data   = push_data_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core; expected events queued per frame, checked by a monitor
module tb_uart_rx_core;
  logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, parity_en = 1'b0, parity_odd = 1'b0, fifo_full = 1'b0;
  logic [15:0] baud_div = '0;
  logic push, parity_err, frame_err, overrun_err, busy;
  logic [7:0] push_data;
  int n_chk = 0, fails = 0, cyc = 0, fall_cyc = 0, last_push_cyc = -1;
  typedef struct packed {logic [2:0] kind; logic perr; logic [7:0] data;} ev_t;
  ev_t sb[$];
  uart_rx_core dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx_in(rx_in), .parity_en(parity_en),
    .parity_odd(parity_odd), .fifo_full(fifo_full), .push(push), .push_data(push_data),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst && (push || overrun_err || frame_err || parity_err)) begin
      n_chk++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event got push=%b ovr=%b frm=%b perr=%b data=%h, required no event",
                 push, overrun_err, frame_err, parity_err, push_data);
      end else begin
        e = sb.pop_front();
        if ({push, overrun_err, frame_err, parity_err} !== {e.kind, e.perr} || (push && push_data !== e.data)) begin
          fails++;
          $display("FAIL event got push/ovr/frm/perr=%b%b%b%b data=%h, required %b%b data=%h",
                   push, overrun_err, frame_err, parity_err, push_data, e.kind, e.perr, e.data);
        end
      end
      if (push) last_push_cyc = cyc;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic bit_time();
    repeat (16 * (int'(baud_div) + 1)) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input bit pe, input bit pb, input bit stop_v);
    rx_in = 1'b0;
    fall_cyc = cyc;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      bit_time();
    end
    if (pe) begin
      rx_in = pb;
      bit_time();
    end
    rx_in = stop_v;
    bit_time();
  endtask
  task automatic expect_ev(input logic [2:0] kind, input logic perr, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.perr = perr;
    e.data = data;
    sb.push_back(e);
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s pending_events=%0d, required 0", name, sb.size());
      sb.delete();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_chk += 3;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b, required 0", busy); end
    if (push_data !== 8'h00) begin fails++; $display("FAIL reset_push_data got %h, required 00", push_data); end
    if ({push, parity_err, frame_err, overrun_err} !== 4'b0) begin
      fails++;
      $display("FAIL reset_pulses got %b, required 0000", {push, parity_err, frame_err, overrun_err});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_basic();
    baud_div = 16'd0;
    last_push_cyc = -1;
    expect_ev(3'b100, 1'b0, 8'hA5);
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    drain("basic_a5");
    n_chk += 2;
    if (last_push_cyc - fall_cyc < 152 || last_push_cyc - fall_cyc > 156) begin
      fails++;
      $display("FAIL basic_latency got %0d, required 152..156", last_push_cyc - fall_cyc);
    end
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy got %b, required 0", busy); end
  endtask
  task automatic test_glitch();
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_start got %b, required 1", busy); end
    rx_in = 1'b1;
    repeat (16) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end got %b, required 0", busy); end
    drain("glitch");
  endtask
  task automatic test_parity();
    parity_en = 1'b1;
    parity_odd = 1'b0;
    expect_ev(3'b100, 1'b1, 8'h3C);
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    drain("parity_even_bad");
    expect_ev(3'b100, 1'b0, 8'h3C);
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    drain("parity_even_good");
    parity_odd = 1'b1;
    expect_ev(3'b100, 1'b0, 8'h01);
    send(8'h01, 1'b1, 1'b0, 1'b1);
    drain("parity_odd_good");
    expect_ev(3'b100, 1'b1, 8'h01);
    send(8'h01, 1'b1, 1'b1, 1'b1);
    drain("parity_odd_bad");
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask
  task automatic test_break();
    expect_ev(3'b001, 1'b0, 8'h00);
    send(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (39) bit_time();
    n_chk++;
    if (busy !== 1'b1) begin fails++; $display("FAIL break_busy_low got %b, required 1", busy); end
    drain("break_frame");
    rx_in = 1'b1;
    bit_time();
    n_chk++;
    if (busy !== 1'b0) begin fails++; $display("FAIL break_busy_high got %b, required 0", busy); end
    expect_ev(3'b100, 1'b0, 8'h12);
    send(8'h12, 1'b0, 1'b0, 1'b1);
    drain("break_recover");
  endtask
  task automatic test_overrun();
    fifo_full = 1'b1;
    expect_ev(3'b010, 1'b0, 8'h00);
    send(8'h7E, 1'b0, 1'b0, 1'b1);
    drain("overrun");
    fifo_full = 1'b0;
  endtask
  task automatic test_reset_mid();
    rx_in = 1'b0;
    bit_time();
    for (int i = 0; i < 3; i++) begin
      rx_in = 8'h81 >> i;
      bit_time();
    end
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk += 2;
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b, required 0", busy); end
    if (push_data !== 8'h00) begin fails++; $display("FAIL rstmid_push_data got %h, required 00", push_data); end
    bit_time();
    expect_ev(3'b100, 1'b0, 8'h81);
    send(8'h81, 1'b0, 1'b0, 1'b1);
    drain("rstmid_resend");
  endtask
  task automatic test_back_to_back();
    baud_div = 16'd3;
    expect_ev(3'b100, 1'b0, 8'h00);
    expect_ev(3'b100, 1'b0, 8'hFF);
    send(8'h00, 1'b0, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b0, 1'b1);
    drain("back_to_back");
    baud_div = 16'd0;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_break();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, fails);
    $finish;
  end
endmodule
